// File: rtl/rv_pkg.sv
// Shared RV32I definitions: instruction formats, major opcodes, field helpers.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // Format codes match the core's imm_sel encoding
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100,
    FMT_R = 3'b101
  } fmt_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  // I-type shifts carry funct7 in inst[31:25] and a 5-bit shamt
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and synchronous clear.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and flags; clear wins over push/pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      full_o  <= (count_next == CNT_W'(DEPTH));
      empty_o <= (count_next == '0);
    end
  end

  // Storage; reset to zero so the head reads zero out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push && !clear_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/rv_inst_encoder.sv
// Encodes RV32I instruction fields into words and streams them into instruction memory.
module rv_inst_encoder
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              imem_wren_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W:0]   wr_count_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [XLEN-1:0] word;
  logic            legal;
  logic            fits_12;
  logic            fits_b;
  logic            fits_j;
  logic            accept;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;

  // Immediate range checks expressed as sign-extension tests
  assign fits_12 = (imm_i[31:11] == {21{imm_i[11]}});
  assign fits_b  = (imm_i[31:12] == {20{imm_i[12]}}) && !imm_i[0];
  assign fits_j  = (imm_i[31:20] == {12{imm_i[20]}}) && !imm_i[0];

  // Field placement and legality per instruction format
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt_t'(fmt_i))
      FMT_R: begin
        word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal = 1'b1;
      end
      FMT_I: begin
        if (is_shift(funct3_i)) begin
          word  = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
          legal = 1'b1;
        end else begin
          word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          legal = fits_12;
        end
      end
      FMT_S: begin
        word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal = fits_12;
      end
      FMT_B: begin
        word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                 imm_i[4:1], imm_i[11], opcode_i};
        legal = fits_b;
      end
      FMT_U: begin
        word  = {imm_i[31:12], rd_i, opcode_i};
        legal = (imm_i[11:0] == 12'h000);
      end
      FMT_J: begin
        word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal = fits_j;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Handshake and FIFO control; flush suppresses both sides
  assign req_ready_o = !full;
  assign accept      = req_valid_i && req_ready_o;
  assign push        = accept && legal && !flush_i;
  assign pop         = imem_wren_o && imem_ready_i && !flush_i;
  assign imem_wren_o = !empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (push),
    .data_i  (word),
    .pop_i   (pop),
    .data_o  (imem_wdata_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Write address, saturating write count and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imem_addr_o <= ADDR_W'(BASE_ADDR);
      wr_count_o  <= '0;
      err_o       <= 1'b0;
    end else if (flush_i) begin
      imem_addr_o <= ADDR_W'(BASE_ADDR);
      wr_count_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      if (pop) begin
        imem_addr_o <= imem_addr_o + ADDR_W'(1);
        if (wr_count_o != '1) wr_count_o <= wr_count_o + CNT_W'(1);
      end
      if (accept && !legal) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Directed bench for rv_inst_encoder with a queue scoreboard on the memory write port.
module tb_rv_inst_encoder;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        imem_wren;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;
  logic [2:0]  wr_count;
  logic        err;

  int unsigned  total = 0;
  int unsigned  bad = 0;
  logic [31:0]  exp_q[$];
  logic [1:0]   model_addr = 2'd0;

  always #5 clk = ~clk;

  rv_inst_encoder #(
    .DEPTH     (4),
    .ADDR_W    (2),
    .BASE_ADDR (0)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .fmt_i        (fmt),
    .opcode_i     (opcode),
    .funct3_i     (funct3),
    .funct7_i     (funct7),
    .rd_i         (rd),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .imm_i        (imm),
    .imem_wren_o  (imem_wren),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .imem_ready_i (imem_ready),
    .wr_count_o   (wr_count),
    .err_o        (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
    end
  endtask

  // Drive fields without handshaking
  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  // One-cycle request; legal words are queued for the write-port scoreboard
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input bit legal, input logic [31:0] expw);
    drive(f, op, f3, f7, d, s1, s2, im);
    chk("ready_before_send", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    if (legal) exp_q.push_back(expw);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_wren_low", 32'(imem_wren), 32'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    model_addr = 2'd0;
  endtask

  // Scoreboard: every completed write must match the next expected word and address
  always @(negedge clk) begin
    if (rst_n === 1'b1 && flush === 1'b0 && imem_wren === 1'b1 && imem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        chk("wdata", imem_wdata, exp_q.pop_front());
        chk("waddr", 32'(imem_addr), 32'(model_addr));
        model_addr = model_addr + 2'd1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; imem_ready = 1'b0;
    drive(3'd0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_wren", 32'(imem_wren), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    @(posedge clk); #1;

    // addi x1,x0,5 appears one cycle after acceptance at address 0
    send(3'd0, OP_I, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    chk("lat_wren", 32'(imem_wren), 32'd1);
    chk("lat_addr", 32'(imem_addr), 32'd0);
    chk("lat_wdata", imem_wdata, 32'h0050_0093);

    // sub, sw, beq back to back
    send(3'd5, OP_R, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020_81B3);
    send(3'd1, OP_STORE, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020_A423);
    send(3'd2, OP_BRANCH, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b1, 32'hFE00_0EE3);
    chk("err_before_illegal", 32'(err), 32'd0);

    // odd jal offset is consumed but not written
    send(3'd4, OP_JAL, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0, 32'd0);
    chk("err_after_jal", 32'(err), 32'd1);

    // addi x2,x0,-1 is the 5th word and wraps to address 0
    send(3'd0, OP_I, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0113);
    wait_drain();
    chk("count_5", 32'(wr_count), 32'd5);
    chk("addr_after_wrap", 32'(imem_addr), 32'd1);
    chk("err_sticky", 32'(err), 32'd1);

    // flush with a request present: nothing accepted, state cleared
    drive(3'd0, OP_I, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    req_valid = 1'b1;
    do_flush();
    req_valid = 1'b0;
    chk("flush_count", 32'(wr_count), 32'd0);
    chk("flush_err", 32'(err), 32'd0);
    chk("flush_addr", 32'(imem_addr), 32'd0);
    chk("flush_wren", 32'(imem_wren), 32'd0);
    chk("flush_ready", 32'(req_ready), 32'd1);

    // lui with nonzero low bits is illegal; legal lui then writes
    send(3'd3, OP_LUI, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 1'b0, 32'd0);
    chk("err_lui", 32'(err), 32'd1);
    send(3'd3, OP_LUI, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    // slli x1,x1,3: shift exempt from range, shamt in [24:20]
    send(3'd0, OP_I, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3, 1'b1, 32'h0030_9093);
    // I immediate 2048 is out of range
    send(3'd0, OP_I, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0);
    wait_drain();
    chk("count_2", 32'(wr_count), 32'd2);
    do_flush();

    // illegal format code
    send(3'd6, OP_R, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'd0);
    chk("err_fmt6", 32'(err), 32'd1);
    @(posedge clk); #1;
    chk("fmt6_no_write", 32'(imem_wren), 32'd0);
    do_flush();

    // fill while memory stalls
    imem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(3'd0, OP_I, 3'd0, 7'h00, 5'(k), 5'd0, 5'd0, 32'(k), 1'b1,
           32'(k << 20) | 32'(k << 7) | 32'h13);
    end
    chk("full_ready_low", 32'(req_ready), 32'd0);
    drive(3'd0, OP_I, 3'd0, 7'h00, 5'd9, 5'd0, 5'd0, 32'd9);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("stall_wren", 32'(imem_wren), 32'd1);
      chk("stall_addr", 32'(imem_addr), 32'd0);
      chk("stall_wdata", imem_wdata, 32'h0010_0093);
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    wait_drain();
    chk("count_4", 32'(wr_count), 32'd4);
    chk("addr_wrapped", 32'(imem_addr), 32'd0);

    // four more at full rate; count saturates at all-ones
    for (int k = 1; k <= 4; k++) begin
      send(3'd0, OP_I, 3'd0, 7'h00, 5'(k), 5'd0, 5'd0, 32'(k), 1'b1,
           32'(k << 20) | 32'(k << 7) | 32'h13);
    end
    wait_drain();
    chk("count_sat", 32'(wr_count), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_inst_encoder.md
# rv_inst_encoder

Streams RV32I instruction fields into 32-bit instruction words and writes them, in order, into the instruction-memory write port. It does the reverse of the core's control-unit decode. Built-in self-test and boot loaders use it to build programs in instruction memory without hand-assembled hex. It has a request handshake on the input side, a FIFO buffer, and an address-counting memory writer on the output side.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2).
- ADDR_W, 11: instruction-memory word-address width.
- BASE_ADDR, 0: first word address after reset or flush.

Ports:
- clk_i  in  1  clock; the block runs on a single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  clears the FIFO and returns the address to BASE_ADDR.
- req_valid_i  in  1  the request fields below are valid.
- req_ready_o  out  1  the block can accept a request.
- fmt_i  in  3  instruction format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R; 110 and 111 are illegal.
- opcode_i  in  7  inst[6:0].
- funct3_i  in  3  inst[14:12].
- funct7_i  in  7  inst[31:25]; used for R-type and for I-type shifts.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- imm_i  in  32  signed immediate value. For U-type this is the full value; the block encodes imm_i[31:12].
- imem_wren_o  out  1  write request.
- imem_addr_o  out  ADDR_W  word address.
- imem_wdata_o  out  32  encoded instruction.
- imem_ready_i  in  1  memory accepts the write this cycle.
- wr_count_o  out  ADDR_W+1  words written since the last reset or flush; saturates at all-ones.
- err_o  out  1  sticky: an illegal request was rejected.

## Operation
- A request is accepted on a rising edge where req_valid_i and req_ready_o are both high.
- req_ready_o = !full. There is no bypass, so a full FIFO does not accept a request even if it pops in the same cycle.
- Encoding is combinational from the request fields. On acceptance, a legal word is pushed into the FIFO.
- Field placement per format:
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode. When funct3 is 001 or 101 (shift), inst[31:25] = funct7_i and inst[24:20] = imm_i[4:0].
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Legality checks. A request is illegal if any of these fails:
  - I and S: imm_i in [-2048, 2047]. I-type shifts are exempt.
  - B: imm_i in [-4096, 4094] and imm_i[0] = 0.
  - J: imm_i in [-2^20, 2^20-2] and imm_i[0] = 0.
  - U: imm_i[11:0] = 0.
  - fmt_i must not be 110 or 111.
- An illegal request is still handshaken (consumed), but nothing is pushed and err_o is set.
- err_o clears only on reset or flush.
- Writer behaviour:
  - imem_wren_o = FIFO not empty; imem_wdata_o = FIFO head; imem_addr_o = the address register.
  - When imem_wren_o and imem_ready_i are both high: pop the FIFO, increment the address, and increment wr_count_o.
  - The address wraps from 2^ADDR_W-1 to 0.
- Flush:
  - The FIFO empties and the address returns to BASE_ADDR; wr_count_o and err_o clear.
  - Flush takes priority over an accept and a write in the same cycle: neither takes effect.
  - req_ready_o stays high during flush.

## Timing
- Reset values:
  - req_ready_o = 1, imem_wren_o = 0, imem_addr_o = BASE_ADDR, imem_wdata_o = 0, wr_count_o = 0, err_o = 0.
  - The FIFO is empty.
- Latency: a word accepted at edge N is presented with imem_wren_o high in cycle N+1 if the FIFO was empty.
- Throughput: one word per cycle when imem_ready_i is held high.
- Push and pop can occur in the same cycle; occupancy is then unchanged.
- Outputs are stable while imem_ready_i is low.
- err_o rises in the cycle after the illegal request is accepted.
- If reset asserts mid-stream, all state is lost immediately (asynchronously); no partial write is retried.

## Structure
- Shared package rv_pkg holds:
  - the fmt_t enum (same codes as the core's imm_sel);
  - opcode constants OP_R = 7'h33, OP_I = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_BRANCH = 7'h63, OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67.
- One sub-module, sync_fifo (parameters DEPTH and WIDTH = 32), provides push, pop, full and empty.
- The encoder logic and the writer logic stay in the top level.

## Test plan
- addi x1,x0,5 (fmt I, opcode 0x13, funct3 0, rd 1, imm 5) → one cycle later imem_wdata_o = 0x00500093 at address 0.
- sub x3,x1,x2 (fmt R, opcode 0x33, funct7 0x20) then sw x2,8(x1) (fmt S, opcode 0x23, funct3 2) → 0x402081B3 at address 0, then 0x0020A423 at address 1.
- beq x0,x0,-4 (fmt B, opcode 0x63) → 0xFE000EE3.
- jal x1 with imm 3 → the request is consumed, no write occurs, err_o = 1; the next legal request still writes.
- Hold imem_ready_i = 0 and push 4 words → req_ready_o drops after the 4th. Release → 4 consecutive writes at addresses 0..3, and wr_count_o = 4.
- With ADDR_W = 2: write 5 words → the 5th goes to address 0. Flush together with req_valid_i → nothing is accepted, the address returns to 0, and wr_count_o = 0.
